path_replay: RTL and testbench
==============================

Name: path_replay

Overview:
- Consumes the direction stack built by the maze solver once the search finishes.
- Walks the stack contents from bottom (index 0) to top (index depth-1), so the path is replayed in forward order from the start cell.
- Emits one 2-bit move per valid/ready handshake and tracks the resulting row/column.
- Feeds the path display/checker stage downstream. Reads the stack storage through a combinational read port and never pops it.

Parameters:
- DEPTH_W, 9: width of the stack depth/index; supports up to 256 entries.
- COORD_W, 4: width of the row and column coordinates; 16x16 grid.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  begin a replay; sampled only in IDLE.
- depth  input  DEPTH_W  number of valid stack entries (stack top index).
- rd_addr  output  DEPTH_W  stack read address.
- rd_data  input  2  stack entry at rd_addr, valid in the same cycle (combinational read).
- move  output  2  current move: 00 up (row-1), 01 right (col+1), 10 left (col-1), 11 down (row+1).
- move_valid  output  1  move is presented.
- move_ready  input  1  downstream accepts move.
- row  output  COORD_W  current row; updated after each accepted move.
- col  output  COORD_W  current column; updated after each accepted move.
- busy  output  1  replay in progress.
- done  output  1  one-cycle pulse when replay completes.
- err  output  1  sticky out-of-grid flag; cleared by the next accepted start.

Behaviour:
- Reset (async, any state): state=IDLE; rd_addr, move, row, col, len all 0; move_valid, busy, done, err all 0.
- States:
  - IDLE
  - LOAD
  - EMIT
  - FIN
- IDLE:
  - busy=0.
  - start=1 → capture len<=depth, idx<=0, row<=0, col<=0, err<=0.
  - Next state is LOAD if depth!=0, else FIN.
- LOAD:
  - busy=1; rd_addr=idx.
  - move<=rd_data registered, move_valid<=1, next state EMIT.
  - Exactly one cycle.
- EMIT:
  - move and move_valid are held stable until move_ready=1.
  - On handshake (move_valid & move_ready), in the same clock edge:
    - Apply the move to row/col.
    - idx<=idx+1; move_valid<=0.
    - Next state is FIN if idx==len-1, else LOAD.
- FIN: done=1 for exactly one cycle, busy=0, next state IDLE.
- Throughput: one move per 2 cycles when move_ready is held high; latency from start to first move_valid is 2 cycles.
- Coordinate rule:
  - A move that would leave the grid sets err=1 and leaves that coordinate unchanged (no wrap-around).
  - Cases: up at row 0, left at col 0, down at row 2^COORD_W-1, right at col 2^COORD_W-1.
  - The move still counts as consumed.
- depth is sampled only at start; later changes are ignored.
- start asserted while not in IDLE is ignored; start held high in the FIN cycle is not accepted until IDLE.
- depth=256 (full stack) is legal; idx/len use DEPTH_W bits, so there is no overflow.
- rd_addr is held at its last value outside LOAD.
- row/col/err keep their final values in IDLE until the next accepted start.
- Reset mid-replay aborts immediately with no done pulse.

Test Plan:
- Stack [01,01,11] (bottom→top), depth=3, start, move_ready=1 → moves 01,01,11 in order; final row=1, col=2; done pulse; err=0; first move_valid 2 cycles after start.
- depth=0, start → no move_valid; done pulses on the cycle after start; row=col=0.
- Stack [00] (up at origin), depth=1 → move 00 emitted; row stays 0; err=1 after handshake; next start with a valid path clears err.
- move_ready held 0 for 5 cycles during EMIT → move and move_valid stable, row/col unchanged; released → single update, no duplicate move.
- 256-entry stack of alternating 01/11 → 256 handshakes, final col=15, row=15, err=1 (overflow clamps), done once.
- rst asserted mid-EMIT → all outputs 0 asynchronously, IDLE, no done; a subsequent start replays from index 0.

Source files
------------

// File: rtl/path_replay.sv
`default_nettype none
// ============================================================================
//  Module      : path_replay
//  Description : Replays the maze-solver direction stack from bottom to top,
//                emitting one 2-bit move per valid/ready handshake and
//                tracking the resulting row/column with out-of-grid clamping.
//  Revision    : 1.0 - initial release
// ============================================================================
module path_replay #(
   parameter int DEPTH_W = 9,
   parameter int COORD_W = 4
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic [DEPTH_W-1:0] depth,
   output logic [DEPTH_W-1:0] rd_addr,
   input  logic [1:0]         rd_data,
   output logic [1:0]         move,
   output logic               move_valid,
   input  logic               move_ready,
   output logic [COORD_W-1:0] row,
   output logic [COORD_W-1:0] col,
   output logic               busy,
   output logic               done,
   output logic               err
);

   localparam logic [DEPTH_W-1:0] IDX_ONE   = DEPTH_W'(1);
   localparam logic [COORD_W-1:0] COORD_ONE = COORD_W'(1);
   localparam logic [COORD_W-1:0] COORD_MAX = '1;

   localparam logic [1:0] MV_UP    = 2'b00;
   localparam logic [1:0] MV_RIGHT = 2'b01;
   localparam logic [1:0] MV_LEFT  = 2'b10;
   localparam logic [1:0] MV_DOWN  = 2'b11;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_LOAD = 2'd1,
      S_EMIT = 2'd2,
      S_FIN  = 2'd3
   } state_t;

   state_t               state;
   state_t               state_nxt;
   logic [DEPTH_W-1:0]   len;
   logic [DEPTH_W-1:0]   idx;
   logic [COORD_W-1:0]   row_nxt;
   logic [COORD_W-1:0]   col_nxt;
   logic                 oob;
   logic                 last;

   // The entry being emitted is the final one when idx reaches len-1;
   // len=0 never reaches EMIT, so the wrap of len-1 is harmless.
   assign last = (idx == (len - IDX_ONE));

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state decode plus the purely state-derived status outputs.
   always_comb begin
      state_nxt = state;
      busy      = 1'b0;
      done      = 1'b0;
      case (state)
         S_IDLE: begin
            if (start) begin
               state_nxt = (depth != '0) ? S_LOAD : S_FIN;
            end
         end
         S_LOAD: begin
            busy      = 1'b1;
            state_nxt = S_EMIT;
         end
         S_EMIT: begin
            busy = 1'b1;
            if (move_valid && move_ready) begin
               state_nxt = last ? S_FIN : S_LOAD;
            end
         end
         S_FIN: begin
            done      = 1'b1;
            state_nxt = S_IDLE;
         end
         default: begin
            state_nxt = S_IDLE;
         end
      endcase
   end

   // Position after applying the presented move; an off-grid step is
   // flagged and leaves the coordinate where it is.
   always_comb begin
      row_nxt = row;
      col_nxt = col;
      oob     = 1'b0;
      case (move)
         MV_UP: begin
            if (row == '0) oob = 1'b1;
            else           row_nxt = row - COORD_ONE;
         end
         MV_RIGHT: begin
            if (col == COORD_MAX) oob = 1'b1;
            else                  col_nxt = col + COORD_ONE;
         end
         MV_LEFT: begin
            if (col == '0) oob = 1'b1;
            else           col_nxt = col - COORD_ONE;
         end
         MV_DOWN: begin
            if (row == COORD_MAX) oob = 1'b1;
            else                  row_nxt = row + COORD_ONE;
         end
         default: begin
            oob = 1'b0;
         end
      endcase
   end

   // Replay datapath: capture on start, fetch in LOAD, commit on handshake.
   // rd_addr is only advanced on the way into LOAD so it holds otherwise.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_addr    <= '0;
         move       <= '0;
         move_valid <= 1'b0;
         row        <= '0;
         col        <= '0;
         err        <= 1'b0;
         len        <= '0;
         idx        <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (start) begin
                  len <= depth;
                  idx <= '0;
                  row <= '0;
                  col <= '0;
                  err <= 1'b0;
                  if (depth != '0) begin
                     rd_addr <= '0;
                  end
               end
            end
            S_LOAD: begin
               move       <= rd_data;
               move_valid <= 1'b1;
            end
            S_EMIT: begin
               if (move_valid && move_ready) begin
                  row        <= row_nxt;
                  col        <= col_nxt;
                  idx        <= idx + IDX_ONE;
                  move_valid <= 1'b0;
                  if (oob) begin
                     err <= 1'b1;
                  end
                  if (!last) begin
                     rd_addr <= idx + IDX_ONE;
                  end
               end
            end
            default: begin
               move_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_path_replay.sv
`default_nettype none
// ============================================================================
//  Module      : tb_path_replay
//  Description : Self-checking bench for path_replay. A transaction-level
//                model replays a snapshot of the stack with clamped grid
//                arithmetic and is compared against the DUT every cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_path_replay;

   localparam int DEPTH_W = 9;
   localparam int COORD_W = 4;
   localparam int CMAX    = (1 << COORD_W) - 1;

   logic               clk;
   logic               rst;
   logic               start;
   logic [DEPTH_W-1:0] depth;
   logic [DEPTH_W-1:0] rd_addr;
   logic [1:0]         rd_data;
   logic [1:0]         move;
   logic               move_valid;
   logic               move_ready;
   logic [COORD_W-1:0] row;
   logic [COORD_W-1:0] col;
   logic               busy;
   logic               done;
   logic               err;

   path_replay #(.DEPTH_W(DEPTH_W), .COORD_W(COORD_W)) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .depth      (depth),
      .rd_addr    (rd_addr),
      .rd_data    (rd_data),
      .move       (move),
      .move_valid (move_valid),
      .move_ready (move_ready),
      .row        (row),
      .col        (col),
      .busy       (busy),
      .done       (done),
      .err        (err)
   );

   // Stack storage with combinational read port.
   logic [1:0] stk  [0:511];
   logic [1:0] snap [0:511];
   assign rd_data = stk[rd_addr];

   int n_pass  = 0;
   int n_total = 0;

   // Ready policy: 0 always high, 1 random, 2 manual.
   int   ready_mode   = 0;
   logic manual_ready = 1'b0;
   bit   noisy        = 1'b0;

   // Reference model state.
   int m_row, m_col, m_err, m_k, m_len;
   bit m_busy, m_load, m_done;
   bit exp_mv, nd, nl;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input int act, input int exp);
      n_total++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
   endtask

   // Ready driver.
   always @(posedge clk) begin
      #1;
      case (ready_mode)
         0:       move_ready = 1'b1;
         1:       move_ready = 1'($urandom_range(0, 1));
         default: move_ready = manual_ready;
      endcase
   end

   // Model: a replay is a snapshot of depth moves; each accepted move steps
   // the position with clamping. Compared against the DUT each negedge.
   always @(negedge clk) begin
      if (rst) begin
         m_row = 0; m_col = 0; m_err = 0; m_k = 0; m_len = 0;
         m_busy = 0; m_load = 0; m_done = 0;
      end else begin
         exp_mv = m_busy && !m_load;
         check("row",        int'(row),        m_row);
         check("col",        int'(col),        m_col);
         check("err",        int'(err),        m_err);
         check("busy",       int'(busy),       int'(m_busy));
         check("done",       int'(done),       int'(m_done));
         check("move_valid", int'(move_valid), int'(exp_mv));
         if (exp_mv) check("move", int'(move), int'(snap[m_k]));
         nd = 0;
         nl = 0;
         if (exp_mv && move_ready) begin
            case (snap[m_k])
               2'b00:   if (m_row == 0)    m_err = 1; else m_row--;
               2'b01:   if (m_col == CMAX) m_err = 1; else m_col++;
               2'b10:   if (m_col == 0)    m_err = 1; else m_col--;
               default: if (m_row == CMAX) m_err = 1; else m_row++;
            endcase
            m_k++;
            if (m_k == m_len) begin m_busy = 0; nd = 1; end
            else nl = 1;
         end else if (!m_busy && !m_done && start) begin
            m_len = int'(depth);
            for (int i = 0; i < m_len; i++) snap[i] = stk[i];
            m_row = 0; m_col = 0; m_err = 0; m_k = 0;
            if (m_len != 0) begin m_busy = 1; nl = 1; end
            else nd = 1;
         end
         m_done = nd;
         m_load = nl;
      end
   end

   // Wait for the done pulse; reports the iteration of first move_valid
   // and of done (iteration 0 is the negedge before start is sampled).
   task automatic wait_done(output int it_mv, output int it_done);
      it_mv   = -1;
      it_done = -1;
      for (int i = 0; i < 3000; i++) begin
         @(negedge clk);
         if (move_valid && it_mv < 0) it_mv = i;
         if (done) begin
            it_done = i;
            break;
         end
         @(posedge clk);
         #1;
         if (noisy) begin
            start = 1'($urandom_range(0, 1));
            depth = DEPTH_W'($urandom_range(0, 511));
         end else begin
            start = 1'b0;
         end
      end
      if (it_done < 0) check("done_timeout", 0, 1);
      @(posedge clk);
      #1 start = 1'b0;
   endtask

   task automatic run(input int d, output int it_mv, output int it_done);
      @(posedge clk);
      #1;
      start = 1'b1;
      depth = DEPTH_W'(d);
      wait_done(it_mv, it_done);
   endtask

   int it_mv, it_done, d;

   initial begin
      rst   = 1'b1;
      start = 1'b0;
      depth = '0;
      for (int i = 0; i < 512; i++) stk[i] = 2'b00;
      #2;
      check("rst_row",     int'(row),        0);
      check("rst_col",     int'(col),        0);
      check("rst_mv",      int'(move_valid), 0);
      check("rst_rd_addr", int'(rd_addr),    0);
      repeat (2) @(negedge clk);
      #2 rst = 1'b0;

      // Forward replay of [01,01,11].
      stk[0] = 2'b01; stk[1] = 2'b01; stk[2] = 2'b11;
      run(3, it_mv, it_done);
      check("t1_latency", it_mv, 2);
      check("t1_row", int'(row), 1);
      check("t1_col", int'(col), 2);
      check("t1_err", int'(err), 0);

      // Up at origin: clamped, err set.
      stk[0] = 2'b00;
      run(1, it_mv, it_done);
      check("t3_row", int'(row), 0);
      check("t3_err", int'(err), 1);
      stk[0] = 2'b01;
      run(1, it_mv, it_done);
      check("t3_err_clear", int'(err), 0);
      check("t3_col",       int'(col), 1);

      // Empty stack: done on the cycle after start, no moves.
      run(0, it_mv, it_done);
      check("t2_done_at", it_done, 1);
      check("t2_no_mv",   it_mv,   -1);
      check("t2_col",     int'(col), 0);

      // Backpressure hold for 5 cycles.
      ready_mode   = 2;
      manual_ready = 1'b0;
      stk[0] = 2'b01; stk[1] = 2'b11;
      @(posedge clk); #1 start = 1'b1; depth = 9'd2;
      @(posedge clk); #1 start = 1'b0;
      @(negedge clk);
      repeat (5) begin
         @(negedge clk);
         check("t4_mv_held",   int'(move_valid), 1);
         check("t4_move_held", int'(move),       1);
         check("t4_col_held",  int'(col),        0);
      end
      @(posedge clk); #1 manual_ready = 1'b1;
      wait_done(it_mv, it_done);
      check("t4_row", int'(row), 1);
      check("t4_col", int'(col), 1);

      // Full 256-entry stack of alternating right/down.
      ready_mode = 0;
      for (int i = 0; i < 256; i++) stk[i] = (i % 2 == 0) ? 2'b01 : 2'b11;
      run(256, it_mv, it_done);
      check("t5_row", int'(row), 15);
      check("t5_col", int'(col), 15);
      check("t5_err", int'(err), 1);

      // Reset mid-EMIT, then replay from index 0.
      ready_mode   = 2;
      manual_ready = 1'b0;
      for (int i = 0; i < 10; i++) stk[i] = 2'($urandom_range(0, 3));
      @(posedge clk); #1 start = 1'b1; depth = 9'd10;
      @(posedge clk); #1 start = 1'b0;
      repeat (3) @(negedge clk);
      #2 rst = 1'b1;
      #1;
      check("t6_mv",      int'(move_valid), 0);
      check("t6_move",    int'(move),       0);
      check("t6_busy",    int'(busy),       0);
      check("t6_done",    int'(done),       0);
      check("t6_rd_addr", int'(rd_addr),    0);
      repeat (2) @(negedge clk);
      #2 rst = 1'b0;
      ready_mode = 0;
      run(10, it_mv, it_done);
      check("t6_latency", it_mv, 2);

      // Randomized replays with random ready and start/depth noise.
      repeat (6) begin
         d = int'($urandom_range(1, 40));
         for (int i = 0; i < d; i++) stk[i] = 2'($urandom_range(0, 3));
         ready_mode = 1;
         noisy      = 1'b1;
         run(d, it_mv, it_done);
         noisy      = 1'b0;
      end

      repeat (3) @(negedge clk);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
`default_nettype wire
